// File: rtl/can_mac_pkg.sv
// can_mac_pkg: shared CAN MAC FSM states, ISO 11898-1 field lengths and the CRC-15 step function
package can_mac_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_SOF, S_ARB, S_CTRL, S_DATA, S_CRC,
    S_CRC_DEL, S_ACK, S_ACK_DEL, S_EOF, S_IFS
  } state_t;
  localparam int ID_LEN = 11;
  localparam int ARB_LEN = 12;
  localparam int CTRL_LEN = 6;
  localparam int CRC_LEN = 15;
  localparam int EOF_LEN = 7;
  localparam int IFS_LEN = 3;
  localparam logic [14:0] CRC15_POLY = 15'h4599;
  function automatic logic [14:0] crc15_next(input logic [14:0] crc, input logic b);
    return {crc[13:0], 1'b0} ^ ((b ^ crc[14]) ? CRC15_POLY : 15'h0);
  endfunction
endpackage

// File: rtl/can_crc15.sv
// can_crc15: bit-serial CAN CRC-15 accumulator
// Ports: clk, reset (sync, active-low), clear (zero the register),
//        enable (fold bit_in into the CRC), bit_in, crc[14:0].
module can_crc15
  import can_mac_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic        bit_in,
  output logic [14:0] crc
);
  always_ff @(posedge clk)
    if (!reset || clear) crc <= '0;
    else if (enable) crc <= crc15_next(crc, bit_in);
endmodule

// File: rtl/can_mac_tx_sequencer.sv
// can_mac_tx_sequencer: CAN standard-frame transmit sequencer feeding the bit serializer
// Ports: clk, reset (sync, active-low); frame request tx_start/tx_id/tx_rtr/tx_dlc/tx_data;
//        status tx_busy/tx_done; serializer handshake bit_in/valid/ready and stuffing_enable.
// Build option: define CAN_TX_IFS_EN to append 3 recessive intermission bits after EOF.
module can_mac_tx_sequencer
  import can_mac_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_start,
  input  logic [ID_LEN-1:0] tx_id,
  input  logic              tx_rtr,
  input  logic [3:0]        tx_dlc,
  input  logic [63:0]       tx_data,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              bit_in,
  output logic              valid,
  input  logic              ready,
  output logic              stuffing_enable
);
  state_t state, nxt;
  logic [6:0] cnt, len;
  logic [ID_LEN-1:0] id;
  logic rtr;
  logic [3:0] dlc, nb;
  logic [63:0] data, w, sh;
  logic [14:0] crc;
  logic accept, xfer, last;
  assign accept = (state == S_IDLE) && tx_start;
  assign xfer = valid && ready;
  assign last = cnt == len - 7'd1;
  assign nb = rtr ? 4'd0 : (dlc > 4'd8 ? 4'd8 : dlc);
  assign valid = state != S_IDLE;
  assign tx_busy = valid;
  assign stuffing_enable = state < S_CRC_DEL;
  // Each field is left-aligned in w; the counter shifts the current bit into the MSB.
  assign sh = w << cnt;
  assign bit_in = sh[63];
  always_comb begin
    len = 7'd1;
    w = '1;
    nxt = S_IDLE;
    case (state)
      S_SOF:     begin w = '0; nxt = S_ARB; end
      S_ARB:     begin len = 7'(ARB_LEN); w = {id, rtr, 52'h0}; nxt = S_CTRL; end
      S_CTRL:    begin len = 7'(CTRL_LEN); w = {2'b00, dlc, 58'h0}; nxt = nb == 4'd0 ? S_CRC : S_DATA; end
      S_DATA:    begin len = {nb, 3'b000}; w = data; nxt = S_CRC; end
      S_CRC:     begin len = 7'(CRC_LEN); w = {crc, 49'h0}; nxt = S_CRC_DEL; end
      S_CRC_DEL: nxt = S_ACK;
      S_ACK:     nxt = S_ACK_DEL;
      S_ACK_DEL: nxt = S_EOF;
`ifdef CAN_TX_IFS_EN
      S_EOF:     begin len = 7'(EOF_LEN); nxt = S_IFS; end
`else
      S_EOF:     begin len = 7'(EOF_LEN); nxt = S_IDLE; end
`endif
      S_IFS:     begin len = 7'(IFS_LEN); nxt = S_IDLE; end
      default:   nxt = S_IDLE;
    endcase
  end
  // CRC covers SOF through DATA only.
  can_crc15 u_crc (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (xfer && state < S_CRC),
    .bit_in (bit_in),
    .crc    (crc)
  );
  always_ff @(posedge clk)
    if (!reset) begin
      state <= S_IDLE;
      cnt <= '0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (accept) begin
        state <= S_SOF;
        cnt <= '0;
        id <= tx_id;
        rtr <= tx_rtr;
        dlc <= tx_dlc;
        data <= tx_data;
      end else if (xfer) begin
        cnt <= last ? '0 : cnt + 7'd1;
        if (last) begin
          state <= nxt;
          tx_done <= nxt == S_IDLE;
        end
      end
    end
endmodule
